hilo_muldiv: RTL and testbench

HILO_MULDIV -- requirements
Module: hilo_muldiv

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/hilo_muldiv.sv | 150 +++++++++++++++
 tb/tb_hilo_muldiv.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned ITER = 32;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } opT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } stateT;

endpackage

// File: rtl/hilo_muldiv.sv
// Iterative radix-2 multiply/divide unit owning the architectural HI/LO registers.
// An op spends W cycles in RUN and one in FIXUP, where signs are restored and HI/LO written.
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         startE,
  input  logic [1:0]   opE,
  input  logic [W-1:0] srcaE,
  input  logic [W-1:0] srcbE,
  input  logic         hienE,
  input  logic         loenE,
  input  logic [W-1:0] wdataE,
  input  logic         cancelE,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         busy
);

  localparam int unsigned CW = $clog2(W);

  stateT          state, stateNext;
  logic [CW-1:0]  count;
  logic [2*W-1:0] acc;
  logic [W-1:0]   operand;   // multiplicand or divisor magnitude
  opT             op;
  logic           signA, signB, divZero;

  // Launch decode: cancel in IDLE suppresses a start.
  opT           opIn;
  logic         launch, isSignedIn, isDivIn, sgnAIn, sgnBIn;
  logic [W-1:0] magAIn, magBIn;

  assign opIn       = opT'(opE);
  assign launch     = (state == IDLE) && startE && !cancelE;
  assign isSignedIn = (opIn == MULT) || (opIn == DIV);
  assign isDivIn    = (opIn == DIV) || (opIn == DIVU);
  assign sgnAIn     = isSignedIn && srcaE[W-1];
  assign sgnBIn     = isSignedIn && srcbE[W-1];
  assign magAIn     = sgnAIn ? -srcaE : srcaE;
  assign magBIn     = sgnBIn ? -srcbE : srcbE;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic; cancel wins over both RUN progress and the FIXUP write.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (startE && !cancelE) stateNext = RUN;
      RUN: begin
        if (cancelE)                      stateNext = IDLE;
        else if (count == CW'(ITER - 1))  stateNext = FIXUP;
      end
      FIXUP:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    busy = (state != IDLE);
  end

  // One radix-2 step: shift-add multiply or restoring shift-subtract divide.
  logic [W:0]     mulSum, divTrial;
  logic [2*W-1:0] divShift, stepAcc;
  always_comb begin
    mulSum   = {1'b0, acc[2*W-1:W]} + {1'b0, operand};
    divShift = {acc[2*W-2:0], 1'b0};
    // Remainder shifted left can need W+1 bits, so include the bit shifted out.
    divTrial = {acc[2*W-1], divShift[2*W-1:W]} - {1'b0, operand};
    if ((op == DIV) || (op == DIVU)) begin
      stepAcc = divTrial[W] ? divShift : {divTrial[W-1:0], divShift[W-1:1], 1'b1};
    end else begin
      stepAcc = acc[0] ? {mulSum, acc[W-1:1]} : {1'b0, acc[2*W-1:W], acc[W-1:1]};
    end
  end

  // Sign fixup of the finished magnitude result.
  logic [2*W-1:0] product;
  logic [W-1:0]   resHi, resLo;
  always_comb begin
    product = (signA ^ signB) ? -acc : acc;
    if ((op == DIV) || (op == DIVU)) begin
      if (divZero) begin
        // Dividend magnitude was parked in acc; restoring its sign recovers raw srcaE.
        resLo = '1;
        resHi = signA ? -acc[W-1:0] : acc[W-1:0];
      end else begin
        resLo = (signA ^ signB) ? -acc[W-1:0] : acc[W-1:0];
        resHi = signA ? -acc[2*W-1:W] : acc[2*W-1:W];
      end
    end else begin
      resLo = product[W-1:0];
      resHi = product[2*W-1:W];
    end
  end

  // Operand latch, iteration counter and accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      acc     <= '0;
      operand <= '0;
      op      <= MULT;
      signA   <= 1'b0;
      signB   <= 1'b0;
      divZero <= 1'b0;
    end else if (launch) begin
      count   <= '0;
      op      <= opIn;
      signA   <= sgnAIn;
      signB   <= sgnBIn;
      divZero <= isDivIn && (srcbE == '0);
      if (isDivIn) begin
        acc     <= {{W{1'b0}}, magAIn};
        operand <= magBIn;
      end else begin
        acc     <= {{W{1'b0}}, magBIn};
        operand <= magAIn;
      end
    end else if (state == RUN) begin
      count <= count + CW'(1);
      // Divide-by-zero holds the dividend untouched for the fixup.
      if (!divZero) acc <= stepAcc;
    end
  end

  // HI/LO: mthi/mtlo only while idle, op result at the close of FIXUP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == IDLE) begin
      if (hienE) hi <= wdataE;
      if (loenE) lo <= wdataE;
    end else if ((state == FIXUP) && !cancelE) begin
      hi <= resHi;
      lo <= resLo;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed cases, control corner cases, random ops.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        startE = 1'b0;
  logic [1:0]  opE = 2'd0;
  logic [31:0] srcaE = '0, srcbE = '0, wdataE = '0;
  logic        hienE = 1'b0, loenE = 1'b0, cancelE = 1'b0;
  logic [31:0] hi, lo;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] expHi = '0, expLo = '0;

  hilo_muldiv #(.W(32)) dut (
    .clk(clk), .reset(reset), .startE(startE), .opE(opE), .srcaE(srcaE), .srcbE(srcbE),
    .hienE(hienE), .loenE(loenE), .wdataE(wdataE), .cancelE(cancelE),
    .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic with the architectural special cases.
  function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          ps;
    longint unsigned pu;
    int              sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      2'd0: begin
        ps = longint'(sa) * longint'(sb);
        return 64'(ps);
      end
      2'd1: begin
        pu = {32'd0, a} * {32'd0, b};
        return 64'(pu);
      end
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Called at a negedge; drives a one-cycle start and returns at the next negedge.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    startE = 1'b1; opE = op; srcaE = a; srcbE = b;
    @(negedge clk);
    startE = 1'b0;
  endtask

  // Counts negedges with busy high, bounded; returns at the first idle negedge.
  task automatic waitIdle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [1:0]  ops [6] = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd2};
    logic [31:0] as  [6] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100,
                             32'h8000_0000};
    logic [31:0] bs  [6] = '{32'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] eh  [6] = '{32'd0, 32'h4000_0000, 32'd0, 32'hFFFF_FFFF, 32'd100, 32'd0};
    logic [31:0] el  [6] = '{32'h2A, 32'd0, 32'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    int cyc;
    for (int i = 0; i < 6; i++) begin
      launch(ops[i], as[i], bs[i]);
      waitIdle(cyc);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL dir%0d_latency got %0d want 33", i, cyc); end
      checks++; if (hi !== eh[i]) begin errors++; $display("FAIL dir%0d_hi got %h want %h", i, hi, eh[i]); end
      checks++; if (lo !== el[i]) begin errors++; $display("FAIL dir%0d_lo got %h want %h", i, lo, el[i]); end
      expHi = eh[i]; expLo = el[i];
    end
  endtask

  task automatic test_cancel;
    // mthi in IDLE, then a DIVU cancelled at RUN cycle 10.
    hienE = 1'b1; wdataE = 32'h1234;
    @(negedge clk);
    hienE = 1'b0;
    expHi = 32'h1234;
    checks++; if (hi !== expHi) begin errors++; $display("FAIL mthi got %h want %h", hi, expHi); end
    launch(2'd3, 32'd9, 32'd4);
    repeat (9) @(negedge clk);
    cancelE = 1'b1;
    @(negedge clk);
    cancelE = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b want 0", busy); end
    repeat (40) @(negedge clk);
    checks++; if (hi !== expHi) begin errors++; $display("FAIL cancel_hi got %h want %h", hi, expHi); end
    checks++; if (lo !== expLo) begin errors++; $display("FAIL cancel_lo got %h want %h", lo, expLo); end
    // Cancel in IDLE blocks the launch but not the mtlo.
    startE = 1'b1; opE = 2'd1; srcaE = 32'd5; srcbE = 32'd5;
    cancelE = 1'b1; loenE = 1'b1; wdataE = 32'h5A5A_0001;
    @(negedge clk);
    startE = 1'b0; cancelE = 1'b0; loenE = 1'b0;
    expLo = 32'h5A5A_0001;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_cancel_busy got %b want 0", busy); end
    checks++; if (lo !== expLo) begin errors++; $display("FAIL idle_cancel_lo got %h want %h", lo, expLo); end
  endtask

  task automatic test_busy_ignore;
    logic [31:0] a, b;
    logic [63:0] r;
    int cyc;
    a = $urandom; b = $urandom;
    r = refModel(2'd1, a, b);
    launch(2'd1, a, b);
    repeat (4) @(negedge clk);
    loenE = 1'b1; hienE = 1'b1; wdataE = 32'hABCD;
    startE = 1'b1; opE = 2'd2; srcaE = 32'd77; srcbE = 32'd3;
    @(negedge clk);
    loenE = 1'b0; hienE = 1'b0; startE = 1'b0;
    waitIdle(cyc);
    checks++; if (cyc + 5 !== 33) begin errors++; $display("FAIL ignore_latency got %0d want 33", cyc + 5); end
    checks++; if ({hi, lo} !== r) begin errors++; $display("FAIL ignore_result got %h want %h", {hi, lo}, r); end
    // Simultaneous start and mthi: the write lands, the result later overwrites it.
    r = refModel(2'd0, 32'hFFFF_FFF0, 32'd3);
    hienE = 1'b1; wdataE = 32'hCAFE_F00D;
    launch(2'd0, 32'hFFFF_FFF0, 32'd3);
    hienE = 1'b0;
    checks++; if (hi !== 32'hCAFE_F00D) begin errors++; $display("FAIL start_mthi got %h want cafef00d", hi); end
    waitIdle(cyc);
    checks++; if ({hi, lo} !== r) begin errors++; $display("FAIL start_mthi_result got %h want %h", {hi, lo}, r); end
    {expHi, expLo} = r;
  endtask

  task automatic test_reset_mid;
    int cyc;
    launch(2'd1, 32'd5, 32'd5);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL midreset_hilo got %h want 0", {hi, lo}); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    launch(2'd1, 32'd3, 32'd3);
    waitIdle(cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL postreset_latency got %0d want 33", cyc); end
    checks++; if ({hi, lo} !== 64'd9) begin errors++; $display("FAIL postreset_result got %h want 9", {hi, lo}); end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Back-to-back random ops: each launch is issued on the first idle cycle.
  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [63:0] r;
    int cyc;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = pickOperand();
      b = pickOperand();
      r = refModel(op, a, b);
      launch(op, a, b);
      waitIdle(cyc);
      checks++;
      if (cyc !== 33) begin errors++; $display("FAIL rnd%0d_latency got %0d want 33", i, cyc); end
      checks++;
      if ({hi, lo} !== r) begin
        errors++;
        $display("FAIL rnd%0d op%0d %h,%h got %h want %h", i, op, a, b, {hi, lo}, r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_cancel();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
